// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix coprocessor: op codes, ALU sequencer states,
// and the row-major buffer addressing helper.
package matrix_pkg;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_MUL   = 3'b010;
   localparam logic [2:0] OP_MULR  = 3'b011;
   localparam logic [2:0] OP_DET   = 3'b100;
   localparam logic [2:0] OP_TRANS = 3'b101;
   localparam logic [2:0] OP_OPP   = 3'b110;
   localparam logic [2:0] OP_RST   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   // Buffers are laid out row-major with a fixed MAX_N stride.
   function automatic int unsigned idx_addr(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned max_n);
      return row * max_n + col;
   endfunction

endpackage

// File: rtl/matrix_alu_seq_alu.sv
// Combinational saturating element ALU: one matrix element in, one result out,
// plus a flag telling whether the true result had to be clamped.
module sat_elem_alu
   import matrix_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [2:0]               op,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic signed [DATA_W-1:0] scalar,
   output logic signed [DATA_W-1:0] result,
   output logic                     sat
);

   localparam int unsigned WW = 2 * DATA_W;
   localparam logic signed [WW-1:0] MAXV = WW'({1'b0, {(DATA_W-1){1'b1}}});
   localparam logic signed [WW-1:0] MINV = ~MAXV;

   logic signed [WW-1:0] wide;

   // Full-precision result first, then clamp to the element range.
   always_comb begin
      wide = WW'(a);
      case (op)
         OP_ADD:  wide = WW'(a) + WW'(b);
         OP_SUB:  wide = WW'(a) - WW'(b);
         OP_MULR: wide = WW'(a) * WW'(scalar);
         OP_OPP:  wide = -WW'(a);
         default: wide = WW'(a);
      endcase

      sat    = 1'b0;
      result = wide[DATA_W-1:0];
      if (wide > MAXV) begin
         sat    = 1'b1;
         result = MAXV[DATA_W-1:0];
      end else if (wide < MINV) begin
         sat    = 1'b1;
         result = MINV[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/matrix_alu_seq.sv
// Sequential matrix ALU: walks an NxN submatrix row-major, one read and one
// write per element, with saturating arithmetic and sticky overflow.
module matrix_alu_seq
   import matrix_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned MAX_N  = 5,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [2:0]        size,
   input  logic [DATA_W-1:0] scalar,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              ovf,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic [DATA_W-1:0] b_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   localparam int unsigned IDX_W = 3;
   localparam logic [IDX_W-1:0] MAX_N_L = IDX_W'(MAX_N);

   state_t            state, nxt;
   logic [2:0]        op_q, nxt_op;
   logic [IDX_W-1:0]  size_q, nxt_size, row, nxt_row, col, nxt_col;
   logic [DATA_W-1:0] scalar_q, nxt_scalar;
   logic              nxt_busy, nxt_done, nxt_err, nxt_ovf, nxt_rd_en, nxt_wr_en;
   logic [ADDR_W-1:0] nxt_rd_addr, nxt_wr_addr, lin_addr, tr_addr;
   logic [DATA_W-1:0] alu_res;
   logic              alu_sat;

   sat_elem_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (op_q),
      .a      (a_data),
      .b      (b_data),
      .scalar (scalar_q),
      .result (alu_res),
      .sat    (alu_sat)
   );

   // Read data only arrives during WR, so the write data path is combinational.
   assign wr_data = wr_en ? alu_res : '0;

   always_comb begin
      nxt        = state;
      nxt_op     = op_q;
      nxt_size   = size_q;
      nxt_scalar = scalar_q;
      nxt_row    = row;
      nxt_col    = col;
      nxt_err    = err;
      nxt_ovf    = ovf;

      case (state)
         S_IDLE: begin
            if (start) begin
               nxt_op     = op;
               nxt_size   = size;
               nxt_scalar = scalar;
               nxt_row    = '0;
               nxt_col    = '0;
               nxt_ovf    = 1'b0;
               nxt_err    = 1'b0;
               if (op == OP_RST) begin
                  nxt = S_FIN;
               end else if (op == OP_MUL || op == OP_DET ||
                            size < IDX_W'(2) || size > MAX_N_L) begin
                  nxt_err = 1'b1;
                  nxt     = S_FIN;
               end else begin
                  nxt = S_RD;
               end
            end
         end
         S_RD: nxt = S_WR;
         S_WR: begin
            nxt_ovf = ovf | alu_sat;
            nxt     = S_RD;
            if (col == size_q - IDX_W'(1)) begin
               nxt_col = '0;
               if (row == size_q - IDX_W'(1)) nxt = S_FIN;
               else                           nxt_row = row + IDX_W'(1);
            end else begin
               nxt_col = col + IDX_W'(1);
            end
         end
         S_FIN:   nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase

      // Registered port values are derived from the state being entered.
      lin_addr    = ADDR_W'(idx_addr(32'(nxt_row), 32'(nxt_col), MAX_N));
      tr_addr     = ADDR_W'(idx_addr(32'(nxt_col), 32'(nxt_row), MAX_N));
      nxt_rd_en   = (nxt == S_RD);
      nxt_wr_en   = (nxt == S_WR);
      nxt_rd_addr = nxt_rd_en ? lin_addr : '0;
      nxt_wr_addr = nxt_wr_en ? ((nxt_op == OP_TRANS) ? tr_addr : lin_addr) : '0;
      nxt_busy    = nxt_rd_en | nxt_wr_en;
      nxt_done    = (nxt == S_FIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         op_q     <= '0;
         size_q   <= '0;
         scalar_q <= '0;
         row      <= '0;
         col      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         ovf      <= 1'b0;
         rd_en    <= 1'b0;
         rd_addr  <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
      end else begin
         state    <= nxt;
         op_q     <= nxt_op;
         size_q   <= nxt_size;
         scalar_q <= nxt_scalar;
         row      <= nxt_row;
         col      <= nxt_col;
         busy     <= nxt_busy;
         done     <= nxt_done;
         err      <= nxt_err;
         ovf      <= nxt_ovf;
         rd_en    <= nxt_rd_en;
         rd_addr  <= nxt_rd_addr;
         wr_en    <= nxt_wr_en;
         wr_addr  <= nxt_wr_addr;
      end
   end

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Bench for matrix_alu_seq: buffer memories, a row-major reference model of
// each command, and a per-cycle comparison against the DUT ports.
module tb_matrix_alu_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [2:0] op = '0;
   logic [2:0] size = '0;
   logic [7:0] scalar = '0;
   logic       busy, done, err, ovf, rd_en, wr_en;
   logic [4:0] rd_addr, wr_addr;
   logic [7:0] a_data = '0, b_data = '0, wr_data;

   matrix_alu_seq #(.DATA_W(8), .MAX_N(5), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .size(size), .scalar(scalar),
      .busy(busy), .done(done), .err(err), .ovf(ovf),
      .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .b_data(b_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] addr;
      logic [7:0] data;
   } wr_t;

   logic [7:0] mem_a [32];
   logic [7:0] mem_b [32];
   logic [7:0] res_mem [32];
   wr_t        exp_q [$];
   wr_t        wv;

   int  checks = 0, errors = 0;
   int  cyc = 0, lat = 0, cur_size = 0, rd_count = 0, wr_count = 0, exp_rd = 0, last_done = -1;
   bit  active = 1'b0, exp_err = 1'b0, exp_ovf = 1'b0;

   task automatic check(input string name, input int got, input int expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
      end
   endtask

   // Synchronous buffer read: data valid the cycle after rd_en.
   always @(posedge clk) begin
      if (rd_en) begin
         a_data <= mem_a[rd_addr];
         b_data <= mem_b[rd_addr];
      end
      if (rst_n && wr_en) res_mem[wr_addr] <= wr_data;
   end

   always @(posedge clk) if (active) cyc = cyc + 1;

   // Per-cycle comparison of DUT ports against the model of the current command.
   always @(negedge clk) begin
      if (rst_n) begin
         if (active && cyc >= 1) begin
            check("busy", int'(busy), int'(cyc < lat));
            if (rd_en) begin
               rd_count++;
               check("rd_in_window", int'((int'(rd_addr) % 5 < cur_size) && (int'(rd_addr) / 5 < cur_size)), 1);
            end
            if (wr_en) begin
               wr_count++;
               if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
               else begin
                  wv = exp_q.pop_front();
                  check("wr_addr", int'(wr_addr), int'(wv.addr));
                  check("wr_data", int'(wr_data), int'(wv.data));
               end
            end
            if (done) begin
               check("done_cycle", cyc, lat);
               check("err", int'(err), int'(exp_err));
               check("ovf", int'(ovf), int'(exp_ovf));
               check("writes_left", exp_q.size(), 0);
               check("rd_count", rd_count, exp_rd);
               last_done = cyc;
               active    = 1'b0;
            end else if (cyc >= lat) begin
               check("done_missing", int'(done), 1);
               active = 1'b0;
            end
         end else if (!active) begin
            check("idle_quiet", int'({busy, done, rd_en, wr_en}), 0);
            check("idle_err", int'(err), int'(exp_err));
            check("idle_ovf", int'(ovf), int'(exp_ovf));
         end
      end
   end

   // Builds the expected write list from the element rules, then pulses start.
   task automatic issue(input logic [2:0] o, input int sz, input logic [7:0] sc);
      int  av, bv, sv, v;
      bit  legal;
      wr_t w;
      @(posedge clk); #1;
      op = o; size = 3'(sz); scalar = sc; start = 1'b1;
      exp_q.delete();
      rd_count = 0; wr_count = 0; cur_size = sz; cyc = 0; last_done = -1;
      legal = (o != 3'b010) && (o != 3'b100) && (sz >= 2) && (sz <= 5);
      exp_ovf = 1'b0;
      if (o == 3'b111) begin
         lat = 1; exp_err = 1'b0;
      end else if (!legal) begin
         lat = 1; exp_err = 1'b1;
      end else begin
         lat = 2 * sz * sz + 1; exp_err = 1'b0;
         sv = int'($signed(sc));
         for (int r = 0; r < sz; r++) begin
            for (int c = 0; c < sz; c++) begin
               av = int'($signed(mem_a[r*5+c]));
               bv = int'($signed(mem_b[r*5+c]));
               case (o)
                  3'b000:  v = av + bv;
                  3'b001:  v = av - bv;
                  3'b011:  v = av * sv;
                  3'b110:  v = -av;
                  default: v = av;
               endcase
               if (v > 127)  begin v = 127;  exp_ovf = 1'b1; end
               if (v < -128) begin v = -128; exp_ovf = 1'b1; end
               w.addr = (o == 3'b101) ? 5'(c*5+r) : 5'(r*5+c);
               w.data = 8'(v);
               exp_q.push_back(w);
            end
         end
      end
      exp_rd = (lat > 1) ? sz * sz : 0;
      active = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); size = 3'($urandom); scalar = 8'($urandom);
   endtask

   task automatic wait_done(input bit poke);
      for (int n = 0; n < 300 && active; n++) begin
         @(negedge clk);
         if (poke && n == 3) begin
            start = 1'b1; op = 3'b110; size = 3'd4; scalar = 8'd7;
         end else if (poke && n == 4) begin
            start = 1'b0;
         end
      end
      if (active) begin
         check("done_timeout", 0, 1);
         active = 1'b0;
      end
   endtask

   task automatic clear_mems();
      for (int i = 0; i < 32; i++) begin
         mem_a[i] = '0; mem_b[i] = '0; res_mem[i] = 8'h5A;
      end
   endtask

   task automatic load_add2();
      clear_mems();
      mem_a[0] = 8'd1;  mem_a[1] = 8'd2;  mem_a[5] = 8'd3;  mem_a[6] = 8'd4;
      mem_b[0] = 8'd10; mem_b[1] = 8'd20; mem_b[5] = 8'd30; mem_b[6] = 8'd40;
   endtask

   initial begin
      clear_mems();
      #1 rst_n = 1'b0;
      #2;
      check("reset_outputs", int'({busy, done, err, ovf, rd_en, wr_en}), 0);
      check("reset_addrs", int'({rd_addr, wr_addr, wr_data}), 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // addM 2x2
      load_add2();
      issue(3'b000, 2, 8'd0); wait_done(1'b0);
      check("add_r0", int'(res_mem[0]), 11);
      check("add_r1", int'(res_mem[1]), 22);
      check("add_r5", int'(res_mem[5]), 33);
      check("add_r6", int'(res_mem[6]), 44);
      check("add_done", last_done, 9);
      check("add_ovf", int'(ovf), 0);

      // subM saturation
      clear_mems(); mem_a[0] = 8'h80; mem_b[0] = 8'd1;
      issue(3'b001, 2, 8'd0); wait_done(1'b0);
      check("sub_sat", int'(res_mem[0]), 8'h80);
      check("sub_ovf", int'(ovf), 1);

      // oppM saturation
      clear_mems(); mem_a[0] = 8'h80;
      issue(3'b110, 2, 8'd0); wait_done(1'b0);
      check("opp_sat", int'(res_mem[0]), 127);
      check("opp_ovf", int'(ovf), 1);

      // multMR 3x3, every element clamps low
      clear_mems();
      for (int i = 0; i < 32; i++) mem_a[i] = 8'd50;
      issue(3'b011, 3, 8'hFD); wait_done(1'b0);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) check("mulr_sat", int'(res_mem[r*5+c]), 8'h80);
      check("mulr_writes", wr_count, 9);
      check("mulr_done", last_done, 19);
      check("mulr_ovf", int'(ovf), 1);

      // reset op clears the sticky flag
      issue(3'b111, 3, 8'd0); wait_done(1'b0);
      check("rst_op_ovf", int'(ovf), 0);
      check("rst_op_err", int'(err), 0);

      // transM 3x3
      clear_mems();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) mem_a[r*5+c] = 8'(10*r + c);
      issue(3'b101, 3, 8'd0); wait_done(1'b0);
      check("trans_a5", int'(res_mem[5]), 1);
      check("trans_a2", int'(res_mem[2]), 20);
      check("trans_done", last_done, 19);

      // illegal op and illegal size
      issue(3'b100, 3, 8'd0); wait_done(1'b0);
      check("badop_err", int'(err), 1);
      check("badop_done", last_done, 1);
      check("badop_rd", rd_count, 0);
      issue(3'b111, 2, 8'd0); wait_done(1'b0);
      check("rst_op_err2", int'(err), 0);
      issue(3'b000, 6, 8'd0); wait_done(1'b0);
      check("badsize_err", int'(err), 1);
      check("badsize_done", last_done, 1);
      check("badsize_rd", rd_count, 0);

      // start while busy is ignored
      load_add2();
      issue(3'b000, 2, 8'd0); wait_done(1'b1);
      check("poke_r0", int'(res_mem[0]), 11);
      check("poke_r6", int'(res_mem[6]), 44);
      check("poke_done", last_done, 9);

      // reset mid-command
      for (int i = 0; i < 32; i++) begin mem_a[i] = 8'(i); mem_b[i] = 8'd1; end
      issue(3'b000, 3, 8'd0);
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (wr_en && n >= 4) break;
      end
      check("abort_wr_before", int'(wr_en), 1);
      rst_n = 1'b0; active = 1'b0; exp_q.delete(); exp_err = 1'b0; exp_ovf = 1'b0;
      #1;
      check("abort_wr_en", int'(wr_en), 0);
      check("abort_outputs", int'({busy, done, err, ovf, rd_en}), 0);
      check("abort_addrs", int'({rd_addr, wr_addr, wr_data}), 0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      repeat (6) @(negedge clk);

      // randomized commands
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 32; i++) begin
            mem_a[i] = 8'($urandom); mem_b[i] = 8'($urandom);
         end
         issue(3'($urandom_range(0, 7)), int'($urandom_range(1, 6)), 8'($urandom));
         wait_done(1'b0);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
